// File: rtl/gb_bus_capture_if.sv
// Game Boy cartridge bus capture interface.
// Bundles the asynchronous cartridge pins with the clean clk-domain
// register-write results. The master side drives the cartridge pins
// (the bus or a bench). The slave side is the capture block.
// Optional macro GB_BUS_STATS_EN adds the wr_count and glitch_count
// statistics signals.
interface gb_bus_capture_if;

  // Cartridge side: asynchronous pins.
  logic [2:0] gb_addr;
  logic [7:0] gb_data;
  logic       gb_write_n;
  logic       gb_read_n;

  // MBC side: clean, registered results.
  logic [3:0] wr_strobe;
  logic [7:0] wr_data;
  logic       rd_active;
  logic       bus_err;

`ifdef GB_BUS_STATS_EN
  logic [15:0] wr_count;
  logic [7:0]  glitch_count;
`endif

  // Bus driver: drives the pins and observes the results.
  modport master (
    output gb_addr,
    output gb_data,
    output gb_write_n,
    output gb_read_n,
    input  wr_strobe,
    input  wr_data,
    input  rd_active,
`ifdef GB_BUS_STATS_EN
    input  wr_count,
    input  glitch_count,
`endif
    input  bus_err
  );

  // Capture block: samples the pins and produces the results.
  modport slave (
    input  gb_addr,
    input  gb_data,
    input  gb_write_n,
    input  gb_read_n,
    output wr_strobe,
    output wr_data,
    output rd_active,
`ifdef GB_BUS_STATS_EN
    output wr_count,
    output glitch_count,
`endif
    output bus_err
  );

endinterface

// File: rtl/gb_bus_capture.sv
// gb_bus_capture: clocked front end between the asynchronous Game Boy
// cartridge bus and the MBC register logic.
//
// Every cartridge pin passes through a SYNC_STAGES-deep synchroniser.
// Write pulses are glitch-filtered: gb_write_n must stay low for
// FILTER_CYCLES synced cycles before the write is accepted. An accepted
// write to ROM space (addr[15] = 0) ends in a one-cycle, one-hot
// wr_strobe with the captured data on wr_data. These strobes replace
// the MBC registers that used to be clocked by the write edge.
//
// Optional macro GB_BUS_STATS_EN adds the wr_count (committed strobes,
// wrapping) and glitch_count (filtered glitches, saturating) outputs.
module gb_bus_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  gb_bus_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] wr_n_sync;
  logic [SYNC_STAGES-1:0] rd_n_sync;
  logic [2:0]             addr_sync [SYNC_STAGES];
  logic [7:0]             data_sync [SYNC_STAGES];

  logic       s_wr_n;
  logic       s_rd_n;
  logic [2:0] s_addr;
  logic [7:0] s_data;

  // Shift every pin through its synchroniser chain. On reset the chain
  // holds the idle bus level, so no false write is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_n_sync <= '1;
      rd_n_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= '0;
        data_sync[i] <= '0;
      end
    end else begin
      wr_n_sync    <= {wr_n_sync[SYNC_STAGES-2:0], bus.gb_write_n};
      rd_n_sync    <= {rd_n_sync[SYNC_STAGES-2:0], bus.gb_read_n};
      addr_sync[0] <= bus.gb_addr;
      data_sync[0] <= bus.gb_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= addr_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign s_wr_n = wr_n_sync[SYNC_STAGES-1];
  assign s_rd_n = rd_n_sync[SYNC_STAGES-1];
  assign s_addr = addr_sync[SYNC_STAGES-1];
  assign s_data = data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Write qualification FSM
  // ---------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [4:0] cnt_inc;
  logic       shadow_load;
  logic       err_set;
  logic       glitch;
  logic       commit;

  logic [2:0] shadow_addr;
  logic [7:0] shadow_data;

  logic [3:0] wr_strobe_q;
  logic [7:0] wr_data_q;
  logic       rd_active_q;
  logic       bus_err_q;

  assign cnt_inc = {1'b0, cnt} + 5'd1;

  // Hold the FSM state and the filter counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Decide the next state and the per-cycle control pulses.
  // IDLE counts its own low cycle, so a write qualifies on the cycle
  // where the low count reaches FILTER_CYCLES. A QUAL cycle that sees
  // the write released is a glitch. If read is also asserted, the cycle
  // is flagged as a bus error. Shadow capture runs on every low cycle
  // of QUAL and ACTIVE. A write that ends right at qualification still
  // commits the data it was qualified with.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shadow_load = 1'b0;
    err_set     = 1'b0;
    glitch      = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (!s_wr_n) begin
          state_nxt = QUAL;
          cnt_nxt   = 4'd1;
        end
      end
      QUAL: begin
        if (s_wr_n) begin
          glitch    = 1'b1;
          state_nxt = IDLE;
        end else if (!s_rd_n) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          shadow_load = 1'b1;
          cnt_nxt     = cnt_inc[3:0];
          if (cnt_inc >= 5'(FILTER_CYCLES)) begin
            state_nxt = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (s_wr_n) begin
          state_nxt = COMMIT;
        end else begin
          shadow_load = 1'b1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture address and data on each low cycle. The last value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_addr <= '0;
      shadow_data <= '0;
    end else if (shadow_load) begin
      shadow_addr <= s_addr;
      shadow_data <= s_data;
    end
  end

  // ---------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------

  // Fire the one-hot strobe for ROM-space commits. Other commits leave
  // wr_data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe_q <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_strobe_q <= '0;
      if (commit && !shadow_addr[2]) begin
        wr_strobe_q <= 4'b0001 << shadow_addr[1:0];
        wr_data_q   <= shadow_data;
      end
    end
  end

  // Report an unfiltered read of ROM space as a registered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_active_q <= 1'b0;
    end else begin
      rd_active_q <= !s_rd_n && !s_addr[2];
    end
  end

  // Latch any read/write collision seen during qualification until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if (err_set) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_active = rd_active_q;
  assign bus.bus_err   = bus_err_q;

`ifdef GB_BUS_STATS_EN
  // ---------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------
  logic [15:0] wr_count_q;
  logic [7:0]  glitch_count_q;

  // Count strobe cycles (wrapping) and glitch exits (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q     <= '0;
      glitch_count_q <= '0;
    end else begin
      if (wr_strobe_q != 4'b0000) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (glitch && glitch_count_q != 8'hFF) begin
        glitch_count_q <= glitch_count_q + 8'd1;
      end
    end
  end

  assign bus.wr_count     = wr_count_q;
  assign bus.glitch_count = glitch_count_q;
`endif

endmodule
